wb_queue: RTL

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 113 +++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// Writeback queue merging ALU (port A) and load (port B) results into a single
// register-file write port, with bypass lookup of pending entries.
module wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_a,
    input  logic [4:0]               rd_a,
    input  logic [DW-1:0]            data_a,
    output logic                     ready_a,
    input  logic                     valid_b,
    input  logic [4:0]               rd_b,
    input  logic [DW-1:0]            data_b,
    output logic                     ready_b,
    output logic                     WE3,
    output logic [4:0]               A3,
    output logic [DW-1:0]            WD3,
    input  logic [4:0]               A1,
    input  logic [4:0]               A2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DW-1:0]            fwd1,
    output logic [DW-1:0]            fwd2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [PW:0]     r_count;
    logic [DEPTH-1:0] r_vld;
    logic [4:0]      r_rd   [DEPTH];
    logic [DW-1:0]   r_data [DEPTH];

    logic [PW:0]     w_free;
    logic            w_enq_a;
    logic            w_enq_b;
    logic            w_pop;
    logic [PW-1:0]   w_tail_b;
    logic [PW-1:0]   w_tail_nxt;
    logic [PW:0]     w_count_nxt;
    logic [PW-1:0]   w_lk_idx;

    // Free space is judged on start-of-cycle occupancy; a pop never funds an enqueue.
    assign w_free  = (PW+1)'(DEPTH) - r_count;
    assign ready_a = (w_free != '0);
    assign w_enq_a = valid_a && ready_a && (rd_a != 5'd0);
    assign ready_b = (w_free >= (PW+1)'(2)) || ((w_free != '0) && !w_enq_a);
    assign w_enq_b = valid_b && ready_b && (rd_b != 5'd0);

    assign w_pop       = (r_count != '0);
    assign w_tail_b    = r_tail + PW'(w_enq_a);
    assign w_tail_nxt  = w_tail_b + PW'(w_enq_b);
    assign w_count_nxt = r_count + (PW+1)'(w_enq_a) + (PW+1)'(w_enq_b) - (PW+1)'(w_pop);

    assign WE3   = w_pop;
    assign A3    = w_pop ? r_rd[r_head]   : 5'd0;
    assign WD3   = w_pop ? r_data[r_head] : '0;
    assign count = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PW'(1);
            end
            if (w_enq_a) r_vld[r_tail]   <= 1'b1;
            if (w_enq_b) r_vld[w_tail_b] <= 1'b1;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq_a) begin
            r_rd[r_tail]   <= rd_a;
            r_data[r_tail] <= data_a;
        end
        if (w_enq_b) begin
            r_rd[w_tail_b]   <= rd_b;
            r_data[w_tail_b] <= data_b;
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        fwd1     = '0;
        fwd2     = '0;
        w_lk_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_lk_idx = r_head + PW'(i);
            if (r_vld[w_lk_idx] && (A1 != 5'd0) && (r_rd[w_lk_idx] == A1)) begin
                hit1 = 1'b1;
                fwd1 = r_data[w_lk_idx];
            end
            if (r_vld[w_lk_idx] && (A2 != 5'd0) && (r_rd[w_lk_idx] == A2)) begin
                hit2 = 1'b1;
                fwd2 = r_data[w_lk_idx];
            end
        end
    end

endmodule
